// File: rtl/pixel_frame_streamer.sv
// Frame buffer plus streaming producer for transformer_classifier.
// Streams one raster-order frame, then waits for done or a timeout.
module pixel_frame_streamer #(
  parameter int IMAGE_SIZE     = 8,
  parameter int CLASS_W        = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int TOTAL         = IMAGE_SIZE * IMAGE_SIZE,
  localparam int AW            = $clog2(TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               go,
  output logic               busy,
  output logic               result_valid,
  output logic [CLASS_W-1:0] result_class,
  output logic               timeout,
  output logic [15:0]        frame_count,
  output logic               cls_start,
  output logic               cls_pixel_valid,
  output logic [7:0]         cls_pixel_in,
  input  logic               cls_ready,
  input  logic               cls_done,
  input  logic [CLASS_W-1:0] cls_class
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM,
    WAIT_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]    mem [TOTAL];
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nxt;
  logic [WW-1:0] wcnt;
  logic          last_beat;
  logic          wait_last;
  logic          wr_ok;

  assign idx_nxt   = idx + 1'b1;
  assign last_beat = (idx == AW'(TOTAL - 1));
  assign wait_last = (wcnt == WW'(TIMEOUT_CYCLES - 1));
  assign wr_ok     = (32'(wr_addr) < 32'(TOTAL));
  assign busy      = (state_q != IDLE);

  // Buffer is deliberately not reset; contents survive an abort.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok && state_q == IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go && cls_ready) state_d = PREFETCH;
      end
      PREFETCH: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (last_beat) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (cls_done || wait_last) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      wcnt            <= '0;
      cls_start       <= 1'b0;
      cls_pixel_valid <= 1'b0;
      cls_pixel_in    <= '0;
      result_valid    <= 1'b0;
      result_class    <= '0;
      timeout         <= 1'b0;
      frame_count     <= '0;
    end else begin
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      unique case (state_q)
        PREFETCH: begin
          idx             <= '0;
          cls_pixel_in    <= mem[0];
          cls_start       <= 1'b1;
          cls_pixel_valid <= 1'b1;
        end
        STREAM: begin
          if (last_beat) begin
            cls_start       <= 1'b0;
            cls_pixel_valid <= 1'b0;
            wcnt            <= '0;
          end else begin
            idx          <= idx_nxt;
            cls_pixel_in <= mem[idx_nxt];
          end
        end
        WAIT_DONE: begin
          // done on the final wait cycle still beats the timeout
          if (cls_done) begin
            result_class <= cls_class;
            result_valid <= 1'b1;
            frame_count  <= frame_count + 16'd1;
          end else if (wait_last) begin
            timeout <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Randomized bench for pixel_frame_streamer against a cycle-offset model.
// Model tracks cycles since go acceptance and derives every output.
module tb_pixel_frame_streamer;

  localparam int ISZ   = 8;
  localparam int TOC   = 16;
  localparam int TOTAL = ISZ * ISZ;
  localparam int FIRST = 2;
  localparam int LAST  = TOTAL + 1;
  localparam int WBEG  = TOTAL + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       go = 1'b0;
  logic       busy;
  logic       result_valid;
  logic [1:0] result_class;
  logic       timeout;
  logic [15:0] frame_count;
  logic       cls_start;
  logic       cls_pixel_valid;
  logic [7:0] cls_pixel_in;
  logic       cls_ready = 1'b1;
  logic       cls_done = 1'b0;
  logic [1:0] cls_class = '0;

  pixel_frame_streamer #(
    .IMAGE_SIZE(ISZ),
    .CLASS_W(2),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .go(go),
    .busy(busy),
    .result_valid(result_valid),
    .result_class(result_class),
    .timeout(timeout),
    .frame_count(frame_count),
    .cls_start(cls_start),
    .cls_pixel_valid(cls_pixel_valid),
    .cls_pixel_in(cls_pixel_in),
    .cls_ready(cls_ready),
    .cls_done(cls_done),
    .cls_class(cls_class)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // t = cycles since go was accepted (0 = idle)
  int          t = 0;
  logic [7:0]  img [TOTAL];
  logic [7:0]  e_pix = '0;
  logic [1:0]  e_cls = '0;
  logic [15:0] e_fc = '0;
  logic        e_rv = 1'b0;
  logic        e_to = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        t = 0; e_pix = '0; e_cls = '0; e_fc = '0; e_rv = 0; e_to = 0;
      end else begin
        e_rv = 0;
        e_to = 0;
        if (t == 0) begin
          if (wr_en) img[wr_addr] = wr_data;
          if (go && cls_ready) t = 1;
        end else if (t >= WBEG && cls_done) begin
          e_rv = 1; e_cls = cls_class; e_fc = e_fc + 16'd1; t = 0;
        end else if (t == WBEG + TOC - 1) begin
          e_to = 1; t = 0;
        end else begin
          t++;
        end
        if (t >= FIRST && t <= LAST) e_pix = img[t - FIRST];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("busy", busy, t != 0);
      chk("start", cls_start, t >= FIRST && t <= LAST);
      chk("pvalid", cls_pixel_valid, t >= FIRST && t <= LAST);
      chk("pixel", cls_pixel_in, e_pix);
      chk("rvalid", result_valid, e_rv);
      chk("rclass", result_class, e_cls);
      chk("timeout", timeout, e_to);
      chk("fcount", frame_count, e_fc);
    end
  end

  int first_off, rv_cnt, rv_off, to_cnt, to_off;
  logic [7:0] pix0, pix5, pixl;
  logic busy_rv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wr_en = 0; go = 0; cls_done = 0; cls_ready = 1;
  endtask

  task automatic load(input bit seq);
    for (int k = 0; k < TOTAL; k++) begin
      wr_en = 1;
      wr_addr = 6'(k);
      wr_data = seq ? 8'(k) : 8'($urandom);
      tick();
    end
    quiet();
    tick();
  endtask

  // w: wait cycle carrying cls_done (-1 = never)
  task automatic frame(input int w, input logic [1:0] c, input bit noise,
                       input bit prot, input bit sim_wr, input int rst_at);
    int stop;
    stop = WBEG + ((w > TOC) ? w : TOC) + 3;
    first_off = -1; rv_cnt = 0; rv_off = -1; to_cnt = 0; to_off = -1;
    busy_rv = 1'b1;
    go = 1; cls_ready = 1;
    if (sim_wr) begin
      wr_en = 1; wr_addr = 6'd0; wr_data = 8'h5A;
    end
    tick();
    for (int i = 1; i < stop; i++) begin
      if (i == rst_at) begin
        rst_n = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", cls_start, 0);
        chk("rst_pix", cls_pixel_in, 0);
        chk("rst_fc", frame_count, 0);
        quiet();
        tick();
        tick();
        rst_n = 1;
        return;
      end
      quiet();
      cls_class = 2'($urandom);
      if (noise && i < WBEG) begin
        cls_done = 1'($urandom);
        cls_ready = 1'($urandom);
        go = 1'($urandom);
        wr_en = 1'($urandom);
        wr_addr = 6'($urandom);
        wr_data = 8'($urandom);
      end
      if (prot && i == 10) begin
        wr_en = 1; wr_addr = 6'd5; wr_data = 8'hAA; go = 1;
      end
      if (w >= 0 && i == WBEG + w) begin
        cls_done = 1; cls_class = c;
      end
      #2;
      if (cls_start && first_off < 0) first_off = i;
      if (i == FIRST) pix0 = cls_pixel_in;
      if (i == FIRST + 5) pix5 = cls_pixel_in;
      if (i == LAST) pixl = cls_pixel_in;
      if (result_valid) begin
        rv_cnt++; rv_off = i; busy_rv = busy;
      end
      if (timeout) begin
        to_cnt++; to_off = i;
      end
      tick();
    end
    quiet();
  endtask

  initial begin
    int w;
    #1 rst_n = 0;
    tick(); tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_fc", frame_count, 0);
    chk("reset_rv", result_valid, 0);
    rst_n = 1;
    tick();

    load(1);
    frame(10, 2'd2, 0, 0, 0, -1);
    chk("basic_first", first_off, FIRST);
    chk("basic_pix0", pix0, 8'h00);
    chk("basic_pix5", pix5, 8'h05);
    chk("basic_pixl", pixl, 8'h3F);
    chk("basic_rvcnt", rv_cnt, 1);
    chk("basic_rvoff", rv_off, 77);
    chk("basic_busy_rv", busy_rv, 0);
    chk("basic_class", result_class, 2'd2);
    chk("basic_fc", frame_count, 1);

    go = 1; cls_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("nr_busy", busy, 0);
      chk("nr_start", cls_start, 0);
      tick();
    end
    frame(3, 2'd1, 0, 0, 0, -1);
    chk("nr_first", first_off, 2);
    chk("nr_fc", frame_count, 2);

    frame(4, 2'd3, 0, 1, 0, -1);
    chk("prot_rv", rv_cnt, 1);
    frame(6, 2'd0, 0, 0, 0, -1);
    chk("prot_pix5", pix5, 8'h05);
    chk("prot_fc", frame_count, 4);

    frame(-1, 2'd0, 0, 0, 0, -1);
    chk("to_cnt", to_cnt, 1);
    chk("to_off", to_off, WBEG + TOC);
    chk("to_rv", rv_cnt, 0);
    chk("to_fc", frame_count, 4);
    chk("to_class", result_class, 2'd0);

    frame(TOC - 1, 2'd3, 0, 0, 0, -1);
    chk("edge_rv", rv_cnt, 1);
    chk("edge_to", to_cnt, 0);
    chk("edge_class", result_class, 2'd3);

    frame(2, 2'd1, 0, 0, 1, -1);
    chk("simwr_pix0", pix0, 8'h5A);

    for (int f = 0; f < 8; f++) begin
      load(0);
      w = $urandom_range(0, TOC + 3);
      frame(w, 2'($urandom), 1, 0, 0, -1);
      chk("rnd_rv", rv_cnt, (w < TOC) ? 1 : 0);
      chk("rnd_to", to_cnt, (w < TOC) ? 0 : 1);
    end

    load(1);
    frame(5, 2'd1, 0, 0, 0, FIRST + 30);
    tick();
    frame(5, 2'd2, 0, 0, 0, -1);
    chk("rst_restart", first_off, FIRST);
    chk("rst_pix0", pix0, 8'h00);
    chk("rst_pix5", pix5, 8'h05);
    chk("rst_fc_after", frame_count, 1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
